counter_seq_monitor: RTL and testbench

- Receiving end of the free-running 4-bit counter output: samples the counter's Q bus each enabled cycle and checks that it advances by exactly +1 mod 2^WIDTH.
- Acquires lock after a run of correct increments and flags and counts sequence errors.
- Drops lock after repeated consecutive errors.
- Used on-board as a self-check on the counter path and any pipeline/cabling between counter and consumer.

---
 rtl/counter_seq_monitor_if.sv | 33 +++
 rtl/counter_seq_monitor.sv | 126 ++++++++++++
 tb/tb_counter_seq_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/counter_seq_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_monitor_if
//  Purpose  : Sample/status bundle between a counter consumer and the
//             sequence monitor that checks the counter's +1 progression.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_seq_monitor_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             EN;
   logic [WIDTH-1:0] D;
   logic             CLR_CNT;
   logic             LOCK;
   logic             ERR;
   logic             WRAP;
   logic [WIDTH-1:0] EXP;
   logic [CNT_W-1:0] ERR_CNT;

   // Side that supplies samples and reads status
   modport master (
      output EN, D, CLR_CNT,
      input  LOCK, ERR, WRAP, EXP, ERR_CNT
   );

   // Monitor side
   modport slave (
      input  EN, D, CLR_CNT,
      output LOCK, ERR, WRAP, EXP, ERR_CNT
   );
endinterface
`default_nettype wire

// File: rtl/counter_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_monitor
//  Purpose  : Checks that a sampled counter bus advances by exactly +1 mod
//             2^WIDTH. Locks after LOCK_LEN good steps, pulses ERR on misses
//             while locked, unlocks after UNLOCK_LEN consecutive misses and
//             keeps a saturating error count.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seq_monitor #(
   parameter int WIDTH      = 4,
   parameter int LOCK_LEN   = 4,
   parameter int UNLOCK_LEN = 2,
   parameter int CNT_W      = 8
) (
   input  wire logic             CLK,
   input  wire logic             RST,
   counter_seq_monitor_if.slave  bus
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_SYNC   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       C_LOCK_LEN = 4'(LOCK_LEN);
   localparam logic [3:0]       C_UNL_LEN  = 4'(UNLOCK_LEN);

   state_t           state_q;
   logic [WIDTH-1:0] prev_q;
   logic [3:0]       match_cnt_q;
   logic [3:0]       miss_cnt_q;
   logic             lock_q;
   logic             err_q;
   logic             wrap_q;
   logic [WIDTH-1:0] exp_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic [WIDTH-1:0] inc_d;
   logic             match_d;
   logic             err_d;

   // Match detection against the previous sample and the error-pulse condition
   always_comb begin
      inc_d   = prev_q + C_ONE;
      match_d = (bus.D == inc_d);
      err_d   = bus.EN && (state_q == S_LOCKED) && !match_d;
   end

   // Lock FSM with registered LOCK/ERR/WRAP/EXP; every enabled sample re-aligns prev
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= S_HUNT;
         prev_q      <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         lock_q      <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         exp_q       <= '0;
      end else begin
         err_q  <= 1'b0;
         wrap_q <= 1'b0;
         if (bus.EN) begin
            prev_q <= bus.D;
            exp_q  <= bus.D + C_ONE;
            case (state_q)
               S_SYNC: begin
                  if (match_d) begin
                     match_cnt_q <= match_cnt_q + 4'd1;
                     if ((match_cnt_q + 4'd1) == C_LOCK_LEN) begin
                        state_q    <= S_LOCKED;
                        lock_q     <= 1'b1;
                        miss_cnt_q <= '0;
                     end
                  end else begin
                     match_cnt_q <= '0;
                  end
               end
               S_LOCKED: begin
                  if (match_d) begin
                     miss_cnt_q <= '0;
                     wrap_q     <= (bus.D == '0);
                  end else begin
                     err_q      <= 1'b1;
                     miss_cnt_q <= miss_cnt_q + 4'd1;
                     if ((miss_cnt_q + 4'd1) == C_UNL_LEN) begin
                        state_q     <= S_HUNT;
                        lock_q      <= 1'b0;
                        match_cnt_q <= '0;
                     end
                  end
               end
               // HUNT and any unused encoding: take this sample as the new base
               default: begin
                  match_cnt_q <= '0;
                  lock_q      <= 1'b0;
                  state_q     <= S_SYNC;
               end
            endcase
         end
      end
   end

   // Saturating error counter; a clear coinciding with an error leaves a count of one
   always_ff @(posedge CLK) begin
      if (!RST) begin
         err_cnt_q <= '0;
      end else if (bus.CLR_CNT) begin
         err_cnt_q <= err_d ? C_CNT_ONE : '0;
      end else if (err_d && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + C_CNT_ONE;
      end
   end

   assign bus.LOCK    = lock_q;
   assign bus.ERR     = err_q;
   assign bus.WRAP    = wrap_q;
   assign bus.EXP     = exp_q;
   assign bus.ERR_CNT = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_seq_monitor
//  Purpose  : Self-checking bench for counter_seq_monitor. Vectors carry
//             inputs plus the outputs expected after the sampling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_monitor;

   typedef struct {
      string      name;
      logic       rst_n;
      logic       en;
      logic       clr;
      logic [3:0] d;
      logic       lock;
      logic       err;
      logic       wrap;
      logic [3:0] exp;
      logic [7:0] cnt;
   } vec_t;

   logic CLK = 1'b0;
   logic RST;

   counter_seq_monitor_if #(.WIDTH(4), .CNT_W(8)) bus ();

   counter_seq_monitor #(
      .WIDTH(4), .LOCK_LEN(4), .UNLOCK_LEN(2), .CNT_W(8)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input string name, input logic rst_n, input logic en,
                               input logic clr, input logic [3:0] d, input logic lock,
                               input logic err, input logic wrap, input logic [3:0] exp,
                               input logic [7:0] cnt);
      vec_t v;
      v.name = name; v.rst_n = rst_n; v.en = en; v.clr = clr; v.d = d;
      v.lock = lock; v.err = err; v.wrap = wrap; v.exp = exp; v.cnt = cnt;
      return v;
   endfunction

   // Drive one sample, queue its expectation, then check it after the edge
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge CLK);
      RST         = v.rst_n;
      bus.EN      = v.en;
      bus.D       = v.d;
      bus.CLR_CNT = v.clr;
      sb.push_back(v);
      @(posedge CLK);
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb.pop_front();
         if (bus.LOCK !== e.lock || bus.ERR !== e.err || bus.WRAP !== e.wrap ||
             bus.EXP !== e.exp || bus.ERR_CNT !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got lock=%b err=%b wrap=%b exp=%0d cnt=%0d want lock=%b err=%b wrap=%b exp=%0d cnt=%0d",
                     e.name, bus.LOCK, bus.ERR, bus.WRAP, bus.EXP, bus.ERR_CNT,
                     e.lock, e.err, e.wrap, e.exp, e.cnt);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] p;
      logic [3:0] dd;
      int         ec;

      RST = 1'b0; bus.EN = 1'b0; bus.D = '0; bus.CLR_CNT = 1'b0;

      // ---- table: reset, lock acquisition, wrap, single error, unlock, relock, EN gaps
      tbl.push_back(mk("reset",     0, 1, 0, 4'd9, 0, 0, 0, 4'd0, 8'd0));
      tbl.push_back(mk("hunt0",     1, 1, 0, 4'd0, 0, 0, 0, 4'd1, 8'd0));
      tbl.push_back(mk("sync1",     1, 1, 0, 4'd1, 0, 0, 0, 4'd2, 8'd0));
      tbl.push_back(mk("sync2",     1, 1, 0, 4'd2, 0, 0, 0, 4'd3, 8'd0));
      tbl.push_back(mk("sync3",     1, 1, 0, 4'd3, 0, 0, 0, 4'd4, 8'd0));
      tbl.push_back(mk("lock4",     1, 1, 0, 4'd4, 1, 0, 0, 4'd5, 8'd0));
      tbl.push_back(mk("locked5",   1, 1, 0, 4'd5, 1, 0, 0, 4'd6, 8'd0));
      for (int i = 6; i < 16; i++)
         tbl.push_back(mk("run",    1, 1, 0, 4'(i), 1, 0, 0, 4'(i + 1), 8'd0));
      tbl.push_back(mk("wrap0",     1, 1, 0, 4'd0, 1, 0, 1, 4'd1, 8'd0));
      tbl.push_back(mk("post_wrap", 1, 1, 0, 4'd1, 1, 0, 0, 4'd2, 8'd0));
      for (int i = 2; i < 8; i++)
         tbl.push_back(mk("run2",   1, 1, 0, 4'(i), 1, 0, 0, 4'(i + 1), 8'd0));
      tbl.push_back(mk("skip9",     1, 1, 0, 4'd9,  1, 1, 0, 4'd10, 8'd1));
      tbl.push_back(mk("realign10", 1, 1, 0, 4'd10, 1, 0, 0, 4'd11, 8'd1));
      tbl.push_back(mk("realign11", 1, 1, 0, 4'd11, 1, 0, 0, 4'd12, 8'd1));
      tbl.push_back(mk("stuck_a",   1, 1, 0, 4'd3, 1, 1, 0, 4'd4, 8'd2));
      tbl.push_back(mk("stuck_b",   1, 1, 0, 4'd3, 0, 1, 0, 4'd4, 8'd3));
      tbl.push_back(mk("stuck_hunt",1, 1, 0, 4'd3, 0, 0, 0, 4'd4, 8'd3));
      tbl.push_back(mk("relock4",   1, 1, 0, 4'd4, 0, 0, 0, 4'd5, 8'd3));
      tbl.push_back(mk("relock5",   1, 1, 0, 4'd5, 0, 0, 0, 4'd6, 8'd3));
      tbl.push_back(mk("relock6",   1, 1, 0, 4'd6, 0, 0, 0, 4'd7, 8'd3));
      tbl.push_back(mk("relock7",   1, 1, 0, 4'd7, 1, 0, 0, 4'd8, 8'd3));
      tbl.push_back(mk("relock8",   1, 1, 0, 4'd8, 1, 0, 0, 4'd9, 8'd3));
      tbl.push_back(mk("en_on9",    1, 1, 0, 4'd9,  1, 0, 0, 4'd10, 8'd3));
      tbl.push_back(mk("en_off_a",  1, 0, 0, 4'd5,  1, 0, 0, 4'd10, 8'd3));
      tbl.push_back(mk("en_off_b",  1, 0, 0, 4'd15, 1, 0, 0, 4'd10, 8'd3));
      tbl.push_back(mk("en_on10",   1, 1, 0, 4'd10, 1, 0, 0, 4'd11, 8'd3));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // ---- saturation: alternate miss/match so lock is kept while errors accumulate
      p  = 4'd10;
      ec = 3;
      for (int i = 0; i < 260; i++) begin
         dd = p + 4'd2;
         ec = (ec < 255) ? ec + 1 : 255;
         apply(mk("sat_miss", 1, 1, 0, dd, 1, 1, 0, dd + 4'd1, 8'(ec)));
         p  = dd;
         dd = p + 4'd1;
         apply(mk("sat_match", 1, 1, 0, dd, 1, 0, (dd == 4'd0), dd + 4'd1, 8'(ec)));
         p  = dd;
      end

      // ---- clear while idle, clear with a simultaneous miss, clear alone
      apply(mk("clr_idle", 1, 0, 1, 4'd3, 1, 0, 0, p + 4'd1, 8'd0));
      dd = p + 4'd2;
      apply(mk("clr_err", 1, 1, 1, dd, 1, 1, 0, dd + 4'd1, 8'd1));
      p  = dd;
      dd = p + 4'd1;
      apply(mk("clr_ok", 1, 1, 1, dd, 1, 0, (dd == 4'd0), dd + 4'd1, 8'd0));
      p  = dd;

      // ---- reset mid-SYNC, then minimum-length lock from reset
      apply(mk("rst2",      0, 1, 1, p,     0, 0, 0, 4'd0,  8'd0));
      apply(mk("hunt5",     1, 1, 0, 4'd5,  0, 0, 0, 4'd6,  8'd0));
      apply(mk("sync6",     1, 1, 0, 4'd6,  0, 0, 0, 4'd7,  8'd0));
      apply(mk("sync_miss", 1, 1, 0, 4'd9,  0, 0, 0, 4'd10, 8'd0));
      apply(mk("rst_sync",  0, 1, 0, 4'd10, 0, 0, 0, 4'd0,  8'd0));
      apply(mk("hunt7",     1, 1, 0, 4'd7,  0, 0, 0, 4'd8,  8'd0));
      apply(mk("m8",        1, 1, 0, 4'd8,  0, 0, 0, 4'd9,  8'd0));
      apply(mk("m9",        1, 1, 0, 4'd9,  0, 0, 0, 4'd10, 8'd0));
      apply(mk("m10",       1, 1, 0, 4'd10, 0, 0, 0, 4'd11, 8'd0));
      apply(mk("lock11",    1, 1, 0, 4'd11, 1, 0, 0, 4'd12, 8'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
